// File: rtl/pkt_out_sched.sv
// Output scheduler: emits one metadata beat per packet followed by its payload,
// truncating packets longer than MAX_BEATS and discarding packets flagged for drop.
module pkt_out_sched #(
  parameter int DATA_WIDTH = 512,
  parameter int META_WIDTH = 356,
  parameter int MAX_BEATS  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_meta_valid,
  output logic                    o_meta_ready,
  input  logic [META_WIDTH-1:0]   i_meta_data,
  input  logic                    i_meta_drop,
  input  logic                    i_pl_tvalid,
  output logic                    o_pl_tready,
  input  logic [DATA_WIDTH-1:0]   i_pl_tdata,
  input  logic [DATA_WIDTH/8-1:0] i_pl_tkeep,
  input  logic                    i_pl_tlast,
  output logic                    o_m_tvalid,
  input  logic                    i_m_tready,
  output logic [DATA_WIDTH-1:0]   o_m_tdata,
  output logic [DATA_WIDTH/8-1:0] o_m_tkeep,
  output logic                    o_m_tlast,
  output logic                    o_m_tuser,
  output logic [31:0]             o_pkt_cnt,
  output logic [15:0]             o_drop_cnt,
  output logic                    o_trunc_err,
  output logic                    o_busy
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, META, PAYLOAD, DROP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [META_WIDTH-1:0] r_meta;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [31:0]           r_pkt_cnt;
  logic [15:0]           r_drop_cnt;
  logic                  r_trunc_err;

  logic                  w_meta_hs;
  logic                  w_pl_hs;
  logic                  w_last_slot;
  logic                  w_trunc;
  logic [DATA_WIDTH-1:0] w_meta_ext;

  assign w_meta_hs   = i_meta_valid && o_meta_ready;
  assign w_pl_hs     = i_pl_tvalid && o_pl_tready;
  assign w_last_slot = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_trunc     = (r_state == PAYLOAD) && w_pl_hs && !i_pl_tlast && w_last_slot;
  assign w_meta_ext  = DATA_WIDTH'(r_meta);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_meta      <= '0;
      r_beat_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_trunc_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_trunc_err <= w_trunc;
      if ((r_state == IDLE) && w_meta_hs)
        r_meta <= i_meta_data;
      if ((r_state == META) && i_m_tready)
        r_beat_cnt <= '0;
      else if ((r_state == PAYLOAD) && w_pl_hs)
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      if ((r_state == PAYLOAD) && w_pl_hs && i_pl_tlast && (r_pkt_cnt != '1))
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      // Truncated packets finish in DROP, so they are counted here as well.
      if ((r_state == DROP) && w_pl_hs && i_pl_tlast && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_meta_hs) w_next = i_meta_drop ? DROP : META;
      META:    if (i_m_tready) w_next = PAYLOAD;
      PAYLOAD: if (w_pl_hs) begin
                 if (i_pl_tlast)       w_next = IDLE;
                 else if (w_last_slot) w_next = DROP;
               end
      DROP:    if (w_pl_hs && i_pl_tlast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_meta_ready = 1'b0;
    o_pl_tready  = 1'b0;
    o_m_tvalid   = 1'b0;
    o_m_tdata    = '0;
    o_m_tkeep    = '0;
    o_m_tlast    = 1'b0;
    o_m_tuser    = 1'b0;
    unique case (r_state)
      IDLE: o_meta_ready = 1'b1;
      META: begin
        o_m_tvalid = 1'b1;
        o_m_tdata  = w_meta_ext;
        o_m_tkeep  = '1;
        o_m_tuser  = 1'b1;
      end
      PAYLOAD: begin
        o_m_tvalid  = i_pl_tvalid;
        o_pl_tready = i_m_tready;
        o_m_tdata   = i_pl_tdata;
        o_m_tkeep   = i_pl_tkeep;
        o_m_tlast   = i_pl_tlast || w_last_slot;
      end
      DROP: o_pl_tready = 1'b1;
      default: o_meta_ready = 1'b0;
    endcase
    // Handshake strobes stay low for the whole reset cycle, not just after the edge.
    if (i_rst) begin
      o_meta_ready = 1'b0;
      o_pl_tready  = 1'b0;
      o_m_tvalid   = 1'b0;
    end
  end

  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_trunc_err = r_trunc_err;
  assign o_busy      = (r_state != IDLE) && !i_rst;

endmodule

// File: doc/pkt_out_sched.md
PKT_OUT_SCHED -- requirements
Module: pkt_out_sched

Interface
REQ-001 Parameter DATA_WIDTH, 512: payload and output beat width, bits.
REQ-002 Parameter META_WIDTH, 356: parser metadata width (dest_mac, src_mac, src_ip, dest_ip, version).
REQ-003 Parameter MAX_BEATS, 32: maximum payload beats per packet before truncation.
REQ-004 clk  in  1: the only clock; all logic on rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 meta_valid / meta_ready  in / out  1 / 1: parser metadata handshake.
REQ-007 meta_data  in  META_WIDTH: per-packet metadata.
REQ-008 meta_drop  in  1: qualified by meta_valid; 1 means discard the packet (unknown ethertype).
REQ-009 pl_tvalid / pl_tready  in / out  1 / 1: payload FIFO AXI-Stream handshake.
REQ-010 pl_tdata, pl_tkeep, pl_tlast  in  DATA_WIDTH, DATA_WIDTH/8, 1: payload beat.
REQ-011 m_tvalid / m_tready  out / in  1 / 1: output AXI-Stream handshake.
REQ-012 m_tdata, m_tkeep, m_tlast, m_tuser  out  DATA_WIDTH, DATA_WIDTH/8, 1, 1: output beat; m_tuser=1 marks the metadata beat.
REQ-013 pkt_cnt  out  32: packets fully forwarded; drop_cnt  out  16: packets discarded; trunc_err  out  1: one-cycle pulse on truncation; busy  out  1: state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, META, PAYLOAD, DROP.
REQ-015 IDLE: meta_ready=1, pl_tready=0, m_tvalid=0; on meta_valid, latch meta_data; go to DROP if meta_drop=1, else META.
REQ-016 META: m_tvalid=1, m_tdata = latched metadata zero-extended to DATA_WIDTH, m_tkeep all ones, m_tuser=1, m_tlast=0, pl_tready=0, meta_ready=0; hold all outputs stable until m_tready, then go to PAYLOAD.
REQ-017 PAYLOAD: combinational pass-through: m_tvalid=pl_tvalid, pl_tready=m_tready, m_tdata/m_tkeep=pl_tdata/pl_tkeep, m_tuser=0, m_tlast=pl_tlast or truncation beat; meta_ready=0.
REQ-018 A beat counter SHALL clear on META exit and increment per accepted PAYLOAD beat (pl_tvalid and pl_tready).
REQ-019 Accepting a pl_tlast beat in PAYLOAD SHALL return to IDLE and increment pkt_cnt.
REQ-020 Truncation: if the MAX_BEATS-th accepted beat has pl_tlast=0, m_tlast SHALL be forced to 1 on that beat, trunc_err pulses the next cycle, the state goes to DROP to discard the remainder, and pkt_cnt is not incremented.
REQ-021 DROP: pl_tready=1, m_tvalid=0, meta_ready=0; consume beats until pl_tlast is accepted, then go to IDLE and increment drop_cnt (also for truncated packets).
REQ-022 If pl_tlast is on the MAX_BEATS-th beat, the packet SHALL be normal: no truncation, no error.
REQ-023 Latency: metadata accepted in cycle N SHALL appear on m_tdata in cycle N+1; one IDLE cycle SHALL separate consecutive packets.
REQ-024 pkt_cnt and drop_cnt SHALL saturate at all-ones, not wrap.
REQ-025 Payload beats arriving while not in PAYLOAD or DROP SHALL stall (pl_tready=0), never be dropped.
REQ-026 Exactly one handshake per cycle per interface; no output change while m_tvalid=1 and m_tready=0.

Reset
REQ-027 While rst=1 at a clock edge: state goes to IDLE, pkt_cnt=0, drop_cnt=0, trunc_err=0, beat counter 0, metadata register 0; during the cycle rst is high, m_tvalid, meta_ready, pl_tready and busy SHALL be 0.
REQ-028 Reset mid-packet SHALL abandon the packet with no m_tlast emitted; upstream FIFO flush is the system's responsibility.

Verification
REQ-029 meta (dest_mac=48'h0011_2233_4455, drop=0) plus 3 payload beats, last flagged; m_tready=1 -> 4 output beats, the first with tuser=1 carrying the metadata, tlast on the 4th; pkt_cnt=1.
REQ-030 meta_drop=1 with a 5-beat payload -> no m_tvalid; 5 beats consumed; drop_cnt=1; pkt_cnt=0.
REQ-031 MAX_BEATS=4, 6-beat payload -> 5 output beats, tlast on output beat 5; trunc_err pulse; remaining 2 beats drained; drop_cnt=1.
REQ-032 m_tready toggled 1-0 every cycle during META and PAYLOAD -> m_tdata/m_tvalid stable while stalled; byte-exact payload match.
REQ-033 rst asserted on the 2nd payload beat of a 4-beat packet -> next cycle busy=0, counters 0; the next clean packet forwards correctly.
REQ-034 Two back-to-back metas, with exactly MAX_BEATS beats ending in tlast -> no trunc_err; metadata beat of packet 2 appears 2 cycles after packet 1's tlast handshake.
